i2c_slave_responder: RTL
========================

Name: i2c_slave_responder

Overview:
- I2C target (slave) responder: the bus end opposite our I2C master control/data units.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Receives and ACKs its 7-bit address; in write transactions, accepts and ACKs data bytes; in read transactions, returns a 16-bit register MSB-first.
- Used as an on-chip TMP101 stand-in for loopback and bench testing of the master.

Parameters:
- SlaveAddress, 7'b1001000, 7-bit address answered (TMP101 default).
- SyncStages, 2, synchronizer flip-flops on SCL and SDA inputs (≥2).

Ports:
- clock  input  1  system clock (60 MHz nominal).
- Reset  input  1  asynchronous, active-high reset.
- SCL  input  1  I2C clock from the master; never driven.
- SDA  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1.
- TxData  input  16  read-back value; [15:8] sent first, then [7:0].
- RxData  output  8  last byte received in a write transaction.
- RxValid  output  1  one-clock pulse when RxData updates.
- AddressMatched  output  1  high from a matching address ACK until STOP, repeated START or Reset.
- Busy  output  1  high from START to STOP.

Behaviour:
- Reset values: SDA=z, RxData=0, RxValid=0, AddressMatched=0, Busy=0, state=IDLE. Reset is asynchronous and can occur mid-transaction; the block returns to IDLE and releases SDA immediately.
- Input conditioning: SCL and SDA pass through SyncStages flip-flops, then a one-register edge detector. Event latency is SyncStages+1 clocks after a pin change.
- Events, evaluated on synchronized signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Rise: SCL rising edge. Fall: SCL falling edge.
- Sampling and drive timing: SDA is sampled only on Rise. The block changes its SDA drive only on Fall. Both actions happen in the same clock as the detected event.
- STOP in any state: go to IDLE, release SDA, Busy=0, AddressMatched=0.
- START in any state, including repeated START: go to ADDR, clear bit counter, release SDA, Busy=1, AddressMatched=0. If START and STOP are detected in the same clock, START wins.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits on Rise, MSB first. After the 8th Rise, compare shift[7:1] with SlaveAddress.
    - Match: on the next Fall drive SDA=0, set AddressMatched, latch RW=shift[0], go to ACK_ADDR.
    - Mismatch: go to IGNORE.
  - ACK_ADDR: hold SDA=0 through the ACK Rise. On the following Fall:
    - RW=0: release SDA, go to WR_BYTE.
    - RW=1: load TxData[15:8] into the shift register, drive its MSB, set byte pointer=0, go to RD_BYTE.
  - WR_BYTE: shift 8 bits on Rise. After the 8th Rise: RxData=shift, pulse RxValid for 1 clock. On the next Fall drive SDA=0 and go to ACK_WR.
  - ACK_WR: on the Fall after the ACK Rise, release SDA and return to WR_BYTE. Every byte is ACKed; there is no internal NACK.
  - RD_BYTE: on each Fall after the first bit, drive the next bit. A 1 bit is driven as z, a 0 bit as 0. After the 8th data bit's Fall, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on Rise.
    - 0 (master ACK): toggle the byte pointer. Pointer 1 loads TxData[7:0]; pointer 0 wraps back to TxData[15:8]. On the next Fall drive the new byte's MSB and return to RD_BYTE.
    - 1 (NACK): go to IGNORE with SDA released.
  - IGNORE: SDA released; wait for START or STOP.
- TxData is captured only at byte load; changes mid-byte have no effect.
- The bit counter is 3 bits and wraps from 7 to 0 at byte end.
- Clock stretching is not supported.

Test Plan:
- Read, address 0x91, TxData=16'h1A80, master ACKs byte 1 and NACKs byte 2 → SDA=0 during address ACK; bytes 0x1A then 0x80 appear on SDA; IGNORE until STOP; Busy falls ≤3 clocks after STOP.
- Address mismatch, 0x93 → SDA stays z for the whole frame; AddressMatched=0; RxValid never pulses.
- Write 0x90, 0x01, 0xA5 → ACK after each of the 3 bytes; RxValid pulses twice with RxData=0x01 then 0xA5; RxData holds 0xA5 after STOP.
- Write 0x90, 0x01, then repeated START with read 0x91, TxData=16'h7FF0, master ACKs 3 bytes → bytes 0x7F, 0xF0, 0x7F (wrap); AddressMatched drops at the repeated START and rises again at the second address ACK.
- Reset asserted mid-read while the slave is driving SDA=0 → SDA=z in the same clock; all outputs return to reset values; the next START and address 0x91 are answered normally.
- STOP mid-write after 4 bits → IDLE; no RxValid pulse; RxData unchanged.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// I2C target responder: oversampled SCL/SDA, START/STOP detection, address
// ACK, write-byte capture with ACK, and 16-bit read-back sent MSB-first.
module i2c_slave_responder #(
   parameter logic [6:0] SlaveAddress = 7'b1001000,
   parameter int         SyncStages   = 2
) (
   input  logic        clock,
   input  logic        Reset,
   input  logic        SCL,
   inout  wire         SDA,
   input  logic [15:0] TxData,
   output logic [7:0]  RxData,
   output logic        RxValid,
   output logic        AddressMatched,
   output logic        Busy
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] ADDR     = 3'd1;
   localparam logic [2:0] ACK_ADDR = 3'd2;
   localparam logic [2:0] WR_BYTE  = 3'd3;
   localparam logic [2:0] ACK_WR   = 3'd4;
   localparam logic [2:0] RD_BYTE  = 3'd5;
   localparam logic [2:0] RD_ACK   = 3'd6;
   localparam logic [2:0] IGNORE   = 3'd7;

   logic [SyncStages-1:0] scl_sync, sda_sync;
   logic                  scl_q, sda_q;
   logic                  scl_s, sda_s;
   logic                  start_evt, stop_evt, rise_evt, fall_evt;

   logic [2:0] state;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic [7:0] shift_in;
   logic       sda_low;   // open-drain pull-down enable
   logic       pend;      // byte finished, action due on next SCL fall
   logic       rw;
   logic       ptr;       // 0: high byte of TxData, 1: low byte

   // Open-drain pad: only ever pulls low or floats
   assign SDA = sda_low ? 1'b0 : 1'bz;

   // Synchronizers and edge-detect register; idle bus level is high
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SyncStages-2:0], SCL};
         sda_sync <= {sda_sync[SyncStages-2:0], SDA};
         scl_q    <= scl_sync[SyncStages-1];
         sda_q    <= sda_sync[SyncStages-1];
      end
   end

   assign scl_s     = scl_sync[SyncStages-1];
   assign sda_s     = sda_sync[SyncStages-1];
   assign start_evt = scl_s & scl_q & sda_q & ~sda_s;
   assign stop_evt  = scl_s & scl_q & ~sda_q & sda_s;
   assign rise_evt  = scl_s & ~scl_q;
   assign fall_evt  = ~scl_s & scl_q;
   assign shift_in  = {shift[6:0], sda_s};

   // Protocol FSM: samples on SCL rise, changes SDA drive on SCL fall
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state          <= IDLE;
         bit_cnt        <= 3'd0;
         shift          <= 8'd0;
         sda_low        <= 1'b0;
         pend           <= 1'b0;
         rw             <= 1'b0;
         ptr            <= 1'b0;
         RxData         <= 8'd0;
         RxValid        <= 1'b0;
         AddressMatched <= 1'b0;
         Busy           <= 1'b0;
      end else begin
         RxValid <= 1'b0;
         if (start_evt) begin
            // START wins over a simultaneous STOP
            state          <= ADDR;
            bit_cnt        <= 3'd0;
            sda_low        <= 1'b0;
            pend           <= 1'b0;
            Busy           <= 1'b1;
            AddressMatched <= 1'b0;
         end else if (stop_evt) begin
            state          <= IDLE;
            sda_low        <= 1'b0;
            pend           <= 1'b0;
            Busy           <= 1'b0;
            AddressMatched <= 1'b0;
         end else begin
            case (state)
               ADDR: begin
                  if (rise_evt) begin
                     shift   <= shift_in;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (shift_in[7:1] == SlaveAddress) pend  <= 1'b1;
                        else                               state <= IGNORE;
                     end
                  end else if (fall_evt && pend) begin
                     pend           <= 1'b0;
                     sda_low        <= 1'b1;
                     AddressMatched <= 1'b1;
                     rw             <= shift[0];
                     state          <= ACK_ADDR;
                  end
               end
               ACK_ADDR: begin
                  // ACK rise already passed when the next fall arrives
                  if (fall_evt) begin
                     bit_cnt <= 3'd0;
                     if (rw) begin
                        shift   <= TxData[15:8];
                        sda_low <= ~TxData[15];
                        ptr     <= 1'b0;
                        state   <= RD_BYTE;
                     end else begin
                        sda_low <= 1'b0;
                        state   <= WR_BYTE;
                     end
                  end
               end
               WR_BYTE: begin
                  if (rise_evt) begin
                     shift   <= shift_in;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        RxData  <= shift_in;
                        RxValid <= 1'b1;
                        pend    <= 1'b1;
                     end
                  end else if (fall_evt && pend) begin
                     pend    <= 1'b0;
                     sda_low <= 1'b1;
                     state   <= ACK_WR;
                  end
               end
               ACK_WR: begin
                  if (fall_evt) begin
                     sda_low <= 1'b0;
                     state   <= WR_BYTE;
                  end
               end
               RD_BYTE: begin
                  if (rise_evt) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) pend <= 1'b1;
                  end else if (fall_evt) begin
                     if (pend) begin
                        pend    <= 1'b0;
                        sda_low <= 1'b0;
                        state   <= RD_ACK;
                     end else begin
                        shift   <= {shift[6:0], 1'b0};
                        sda_low <= ~shift[6];
                     end
                  end
               end
               RD_ACK: begin
                  if (rise_evt) begin
                     if (!sda_s) begin
                        ptr   <= ~ptr;
                        shift <= ptr ? TxData[15:8] : TxData[7:0];
                        pend  <= 1'b1;
                     end else begin
                        state <= IGNORE;
                     end
                  end else if (fall_evt && pend) begin
                     pend    <= 1'b0;
                     bit_cnt <= 3'd0;
                     sda_low <= ~shift[7];
                     state   <= RD_BYTE;
                  end
               end
               default: sda_low <= 1'b0;  // IDLE / IGNORE
            endcase
         end
      end
   end

endmodule
